// File: rtl/rgb2hsv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hsv_pipe_pkg
// Description : Shared definitions for the RGB to HSV pipeline: hue sector
//               encoding, angle constants and reciprocal fixed-point format.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rgb2hsv_pipe_pkg;

    // Reciprocals are unsigned fixed point with RCP_FRAC fraction bits.
    // Rcp(1) = 65536 needs one integer bit on top of the fraction.
    localparam int RCP_FRAC = 16;
    localparam int RCP_W    = RCP_FRAC + 1;

    localparam int DEG_60  = 60;
    localparam int DEG_120 = 120;
    localparam int DEG_240 = 240;
    localparam int DEG_360 = 360;

    // Hue in whole degrees, 0..359
    localparam int HUE_W = 9;

    // Which component holds the maximum (ties resolved R, then G, then B)
    typedef enum logic [1:0] {
        SECT_R = 2'd0,
        SECT_G = 2'd1,
        SECT_B = 2'd2
    } sector_e;

    function automatic logic [HUE_W-1:0] sector_offset(input sector_e sector);
        logic [HUE_W-1:0] offset;
        offset = '0;
        case (sector)
            SECT_G:  offset = HUE_W'(DEG_120);
            SECT_B:  offset = HUE_W'(DEG_240);
            default: offset = '0;
        endcase
        return offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2hsv_recip.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hsv_recip
// Description : Registered reciprocal lookup, rcp = round(65536 / x), with
//               rcp = 0 for x = 0. The table is built at elaboration time.
// Ports       : clk  - clock
//               en   - load enable for the output register
//               x    - DATA_W-bit operand
//               rcp  - RCP_W-bit reciprocal, valid the cycle after en
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2hsv_recip
    import rgb2hsv_pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    output logic [RCP_W-1:0]  rcp
);

    localparam int c_DEPTH = 2 ** DATA_W;

    logic [RCP_W-1:0] w_rom [c_DEPTH];
    logic [RCP_W-1:0] r_rcp;

    // (2*65536 + i) / (2*i) is floor(65536/i + 1/2), i.e. exact rounding.
    for (genvar i = 0; i < c_DEPTH; i++) begin : g_rom
        if (i == 0) begin : g_zero
            assign w_rom[i] = '0;
        end else begin : g_entry
            assign w_rom[i] = RCP_W'(((2 ** (RCP_FRAC + 1)) + i) / (2 * i));
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_rcp <= w_rom[x];
        end
    end

    assign rcp = r_rcp;

endmodule
`default_nettype wire

// File: rtl/rgb2hsv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hsv_pipe
// Description : Three-stage valid/ready RGB to HSV converter.
//               Stage 1: max/min/diff, hue sector, signed numerator.
//               Stage 2: reciprocal lookups of max and diff.
//               Stage 3: hue, saturation and value arithmetic.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               clk_en             - global stall
//               in_valid/in_ready  - input handshake
//               in_rgb, in_user    - {R,G,B} pixel and sideband
//               out_valid/out_ready- output handshake
//               out_hsv, out_user  - {H,S,V} pixel and sideband
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2hsv_pipe
    import rgb2hsv_pipe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HUE_MODE = 0,
    parameter int USER_W   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*DATA_W-1:0] in_rgb,
    input  logic [USER_W-1:0]   in_user,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*DATA_W-1:0] out_hsv,
    output logic [USER_W-1:0]   out_user
);

    // 4095 * 4095 * 65536 sits just under 2^40; 48 bits leaves headroom.
    localparam int                  c_PROD_W  = 48;
    localparam logic [DATA_W-1:0]   c_MAX_VAL = '1;
    localparam logic [c_PROD_W-1:0] c_ROUND   = c_PROD_W'(1) << (RCP_FRAC - 1);
    // round(2^(16+DATA_W) / 360)
    localparam longint              c_HUE_K   =
        ((longint'(1) << (RCP_FRAC + DATA_W + 1)) + DEG_360) / (2 * DEG_360);

    // ------------------------------------------------------------------
    // Pipeline control: a stage may load when it is empty or when the
    // stage after it is loading, so bubbles collapse under backpressure.
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid, r_out_valid;
    logic w_s1_ready, w_s2_ready, w_s3_ready;
    logic w_s1_load, w_s2_load, w_s3_load;

    assign w_s3_ready = !r_out_valid || out_ready;
    assign w_s2_ready = !r_s2_valid  || w_s3_ready;
    assign w_s1_ready = !r_s1_valid  || w_s2_ready;

    assign w_s1_load = clk_en && w_s1_ready;
    assign w_s2_load = clk_en && w_s2_ready;
    assign w_s3_load = clk_en && w_s3_ready;

    assign in_ready = clk_en && !rst && w_s1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load) r_s1_valid <= in_valid;
            if (w_s2_load) r_s2_valid <= r_s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      w_r, w_g, w_b, w_max, w_min;
    sector_e                w_sector;
    logic signed [DATA_W:0] w_num;

    assign w_r = in_rgb[3*DATA_W-1 -: DATA_W];
    assign w_g = in_rgb[2*DATA_W-1 -: DATA_W];
    assign w_b = in_rgb[DATA_W-1   -: DATA_W];

    always_comb begin
        w_max    = w_r;
        w_sector = SECT_R;
        w_num    = $signed({1'b0, w_g}) - $signed({1'b0, w_b});
        if (!((w_r >= w_g) && (w_r >= w_b))) begin
            if (w_g >= w_b) begin
                w_max    = w_g;
                w_sector = SECT_G;
                w_num    = $signed({1'b0, w_b}) - $signed({1'b0, w_r});
            end else begin
                w_max    = w_b;
                w_sector = SECT_B;
                w_num    = $signed({1'b0, w_r}) - $signed({1'b0, w_g});
            end
        end
        w_min = w_r;
        if (w_g < w_min) w_min = w_g;
        if (w_b < w_min) w_min = w_b;
    end

    logic [DATA_W-1:0]      r_s1_max, r_s1_diff;
    sector_e                r_s1_sector;
    logic signed [DATA_W:0] r_s1_num;
    logic [USER_W-1:0]      r_s1_user;

    // ------------------------------------------------------------------
    // Stage 2: reciprocals come out of the lookup registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      r_s2_max, r_s2_diff;
    sector_e                r_s2_sector;
    logic signed [DATA_W:0] r_s2_num;
    logic [USER_W-1:0]      r_s2_user;
    logic [RCP_W-1:0]       w_rcp_max, w_rcp_diff;
    logic                   w_s2_take;

    assign w_s2_take = w_s2_load && r_s1_valid;

    // Payload registers need no reset: the valid flags qualify them.
    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_max    <= w_max;
            r_s1_diff   <= w_max - w_min;
            r_s1_sector <= w_sector;
            r_s1_num    <= w_num;
            r_s1_user   <= in_user;
        end
        if (w_s2_take) begin
            r_s2_max    <= r_s1_max;
            r_s2_diff   <= r_s1_diff;
            r_s2_sector <= r_s1_sector;
            r_s2_num    <= r_s1_num;
            r_s2_user   <= r_s1_user;
        end
    end

    rgb2hsv_recip #(
        .DATA_W (DATA_W)
    ) u_rcp_max (
        .clk (clk),
        .en  (w_s2_take),
        .x   (r_s1_max),
        .rcp (w_rcp_max)
    );

    rgb2hsv_recip #(
        .DATA_W (DATA_W)
    ) u_rcp_diff (
        .clk (clk),
        .en  (w_s2_take),
        .x   (r_s1_diff),
        .rcp (w_rcp_diff)
    );

    // ------------------------------------------------------------------
    // Stage 3
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]        w_abs_num;
    logic [c_PROD_W-1:0]      w_hue_prod, w_sat_wide, w_h_wide;
    logic [HUE_W-1:0]         w_hue_mag, w_hue_deg;
    logic signed [HUE_W+1:0]  w_hue_raw;
    logic [DATA_W-1:0]        w_h, w_s;

    assign w_abs_num = DATA_W'(r_s2_num[DATA_W] ? -r_s2_num : r_s2_num);

    // |num| <= diff, so the magnitude rounds to at most about 60 degrees
    assign w_hue_prod = c_PROD_W'(DEG_60) * c_PROD_W'(w_abs_num) * c_PROD_W'(w_rcp_diff)
                      + c_ROUND;
    assign w_hue_mag  = HUE_W'(w_hue_prod >> RCP_FRAC);

    assign w_hue_raw = $signed({2'b00, sector_offset(r_s2_sector)})
                     + (r_s2_num[DATA_W] ? -$signed({2'b00, w_hue_mag})
                                         :  $signed({2'b00, w_hue_mag}));

    // Only the red sector can go negative (300..359 after wrapping)
    assign w_hue_deg = HUE_W'((w_hue_raw < 0) ? w_hue_raw + (HUE_W+2)'(DEG_360)
                                              : w_hue_raw);

    if (HUE_MODE == 0) begin : g_hue_half
        assign w_h_wide = c_PROD_W'(w_hue_deg >> 1);
    end else begin : g_hue_full
        assign w_h_wide = (c_PROD_W'(w_hue_deg) * c_PROD_W'(c_HUE_K) + c_ROUND) >> RCP_FRAC;
    end

    // Saturation also covers half-degree hue at DATA_W below 8
    assign w_h = (w_h_wide > c_PROD_W'(c_MAX_VAL)) ? c_MAX_VAL : DATA_W'(w_h_wide);

    assign w_sat_wide = (c_PROD_W'(r_s2_diff) * c_PROD_W'(c_MAX_VAL) * c_PROD_W'(w_rcp_max)
                       + c_ROUND) >> RCP_FRAC;
    assign w_s = (w_sat_wide > c_PROD_W'(c_MAX_VAL)) ? c_MAX_VAL : DATA_W'(w_sat_wide);

    logic [3*DATA_W-1:0] r_out_hsv;
    logic [USER_W-1:0]   r_out_user;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_hsv   <= '0;
            r_out_user  <= '0;
        end else if (w_s3_load) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_user <= r_s2_user;
                if (r_s2_diff == '0) begin
                    r_out_hsv <= {{(2*DATA_W){1'b0}}, r_s2_max};
                end else begin
                    r_out_hsv <= {w_h, w_s, r_s2_max};
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_hsv   = r_out_hsv;
    assign out_user  = r_out_user;

endmodule
`default_nettype wire

// File: tb/tb_rgb2hsv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2hsv_pipe
// Description : Self-checking bench for rgb2hsv_pipe. Two instances (half-
//               degree and full-range hue) share one input stream; each is
//               scored against an integer HSV model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rgb2hsv_pipe;

    localparam int DW = 8;
    localparam int UW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [3*DW-1:0] in_rgb = '0;
    logic [UW-1:0]   in_user = '0;

    logic            in_ready0, out_valid0, in_ready1, out_valid1;
    logic [3*DW-1:0] out_hsv0, out_hsv1;
    logic [UW-1:0]   out_user0, out_user1;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ready = 1'b0;
    bit fixed_ready = 1'b1;

    typedef struct packed {
        logic [3*DW-1:0] hsv;
        logic [UW-1:0]   user;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e;

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.DATA_W(DW), .HUE_MODE(0), .USER_W(UW)) dut_h0 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready0), .in_rgb(in_rgb), .in_user(in_user),
        .out_valid(out_valid0), .out_ready(out_ready), .out_hsv(out_hsv0), .out_user(out_user0)
    );

    rgb2hsv_pipe #(.DATA_W(DW), .HUE_MODE(1), .USER_W(UW)) dut_h1 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready1), .in_rgb(in_rgb), .in_user(in_user),
        .out_valid(out_valid1), .out_ready(out_ready), .out_hsv(out_hsv1), .out_user(out_user1)
    );

    // ---------------- model ----------------
    function automatic int rcp(input int x);
        if (x == 0) return 0;
        return (131072 + x) / (2 * x);
    endfunction

    function automatic logic [23:0] model(input int r, input int g, input int b, input int mode);
        int mx, mn, diff, off, num, hue, h, s;
        longint mag, k;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        diff = mx - mn;
        if (r == mx)      begin off = 0;   num = g - b; end
        else if (g == mx) begin off = 120; num = b - r; end
        else              begin off = 240; num = r - g; end
        mag = (60 * longint'(num < 0 ? -num : num) * rcp(diff) + 32768) >> 16;
        hue = off + (num < 0 ? -int'(mag) : int'(mag));
        if (hue < 0) hue += 360;
        if (mode == 0) h = hue / 2;
        else begin
            k = ((longint'(1) << 25) + 360) / 720;
            h = int'((hue * k + 32768) >> 16);
        end
        if (h > 255) h = 255;
        s = int'((longint'(diff) * 255 * rcp(mx) + 32768) >> 16);
        if (s > 255) s = 255;
        if (diff == 0) begin h = 0; s = 0; end
        return {8'(h), 8'(s), 8'(mx)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // ---------------- scoreboard / compare ----------------
    logic [3*DW-1:0] hold_hsv;
    logic [UW-1:0]   hold_user;
    bit              hold_pend = 1'b0;

    always @(negedge clk) begin
        if (hold_pend) begin
            check("stall_valid", out_valid0, 1);
            check("stall_hsv", out_hsv0, hold_hsv);
            check("stall_user", out_user0, hold_user);
        end
        hold_pend = 1'b0;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out_valid0 && out_ready && clk_en) begin
                if (q0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_out0: actual %0h required none", out_hsv0);
                end else begin
                    e = q0.pop_front();
                    check("hsv0", out_hsv0, e.hsv);
                    check("user0", out_user0, e.user);
                end
            end else if (out_valid0) begin
                hold_pend = 1'b1;
                hold_hsv  = out_hsv0;
                hold_user = out_user0;
            end
            if (out_valid1 && out_ready && clk_en) begin
                if (q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_out1: actual %0h required none", out_hsv1);
                end else begin
                    e = q1.pop_front();
                    check("hsv1", out_hsv1, e.hsv);
                    check("user1", out_user1, e.user);
                end
            end
            if (in_valid && in_ready0 && clk_en)
                q0.push_back('{hsv: model(in_rgb[23:16], in_rgb[15:8], in_rgb[7:0], 0), user: in_user});
            if (in_valid && in_ready1 && clk_en)
                q1.push_back('{hsv: model(in_rgb[23:16], in_rgb[15:8], in_rgb[7:0], 1), user: in_user});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [UW-1:0] u);
        bit hs;
        int guard;
        hs = 1'b0;
        guard = 0;
        in_rgb = {r, g, b};
        in_user = u;
        in_valid = 1'b1;
        while (!hs) begin
            @(negedge clk);
            hs = in_valid && in_ready0 && clk_en && !rst;
            tick();
            guard++;
            if (!hs && guard > 200) begin
                n_checks++; n_errors++;
                $display("FAIL send_timeout: actual no handshake required handshake");
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL drain_%s: actual %0d pending required 0", tag, q0.size() + q1.size());
        end
    endtask

    logic [23:0] stream_tbl [10] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0080,
                                     24'h808080, 24'h000000, 24'h123456, 24'hFFFF00,
                                     24'h40C020, 24'h0A0B0C};

    // ---------------- main sequence ----------------
    initial begin
        // reset behaviour
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", in_ready0, 0);
            check("rst_out_valid", out_valid0, 0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready0, 1);
        check("post_rst_hsv", out_hsv0, 0);
        check("post_rst_user", out_user0, 0);
        tick();

        // hand-computed pins on the model
        check("model_red",   model(255, 0, 0, 0),     24'h00FFFF);
        check("model_blue",  model(0, 0, 255, 0),     24'h78FFFF);
        check("model_330",   model(255, 0, 128, 0),   24'hA5FFFF);
        check("model_330_m1", model(255, 0, 128, 1),  24'hEBFFFF);
        check("model_grey",  model(128, 128, 128, 0), 24'h000080);

        // primaries back to back: outputs on cycles 3, 4, 5
        send(8'd255, 8'd0, 8'd0, 2'd1);
        send(8'd0, 8'd255, 8'd0, 2'd2);
        send(8'd0, 8'd0, 8'd255, 2'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_red_valid", out_valid0, 1);
        check("dir_red", out_hsv0, 24'h00FFFF);
        @(negedge clk);
        check("dir_green", out_hsv0, 24'h3CFFFF);
        @(negedge clk);
        check("dir_blue", out_hsv0, 24'h78FFFF);
        check("dir_blue_user", out_user0, 2'd3);
        tick();

        // grey and black
        send(8'd128, 8'd128, 8'd128, 2'd0);
        send(8'd0, 8'd0, 8'd0, 2'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bubble_valid", out_valid0, 0);
        @(negedge clk);
        check("dir_grey", out_hsv0, 24'h000080);
        @(negedge clk);
        check("dir_black_valid", out_valid0, 1);
        check("dir_black", out_hsv0, 24'h000000);
        tick();

        // negative numerator wrap, both hue modes
        send(8'd255, 8'd0, 8'd128, 2'd2);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1", out_valid0, 0);
        @(negedge clk);
        check("lat_c2", out_valid0, 0);
        @(negedge clk);
        check("dir_330_h0", out_hsv0, 24'hA5FFFF);
        check("dir_330_h1", out_hsv1, 24'hEBFFFF);
        tick();

        // random backpressure stream
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send(stream_tbl[i][23:16], stream_tbl[i][15:8], stream_tbl[i][7:0], UW'(i));
        in_valid = 1'b0;
        drain("stream");
        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        tick();
        tick();

        // reset with three pixels in flight
        fixed_ready = 1'b0;
        tick();
        send(8'd10, 8'd200, 8'd30, 2'd1);
        send(8'd90, 8'd20, 8'd250, 2'd2);
        send(8'd77, 8'd77, 8'd5, 2'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fixed_ready = 1'b1;
        @(negedge clk);
        check("flush_valid0", out_valid0, 0);
        check("flush_valid1", out_valid1, 0);
        check("flush_hsv", out_hsv0, 0);
        check("flush_in_ready", in_ready0, 1);
        tick();
        send(8'd0, 8'd255, 8'd0, 2'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("rec_c1", out_valid0, 0);
        @(negedge clk);
        check("rec_c2", out_valid0, 0);
        @(negedge clk);
        check("rec_valid", out_valid0, 1);
        check("rec_hsv", out_hsv0, 24'h3CFFFF);
        tick();
        drain("reset");

        // clock-enable stall mid stream
        send(8'd200, 8'd100, 8'd50, 2'd0);
        send(8'd30, 8'd60, 8'd90, 2'd1);
        send(8'd250, 8'd250, 8'd0, 2'd2);
        in_rgb = 24'h5A3C1E;
        in_user = 2'd3;
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready0, 0);
            tick();
        end
        clk_en = 1'b1;
        send(8'h5A, 8'h3C, 8'h1E, 2'd3);
        send(8'd1, 8'd2, 8'd3, 2'd0);
        in_valid = 1'b0;
        drain("clk_en");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rgb2hsv_pipe.md
RGB2HSV_PIPE -- requirements
Module: rgb2hsv_pipe

Interface
REQ-001 Parameter DATA_W, default 8, meaning bits per colour component in and out (legal 6..12).
REQ-002 Parameter HUE_MODE, default 0, meaning 0 = hue in half-degrees (0..179), 1 = hue scaled to full range 0..2^DATA_W-1.
REQ-003 Parameter USER_W, default 1, meaning width of sideband passed unchanged alongside each pixel.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clk_en  input  1  global stall; when low no state changes and no handshakes complete.
REQ-007 in_valid  input  1  input pixel present.
REQ-008 in_ready  output  1  block can accept a pixel this cycle.
REQ-009 in_rgb  input  3*DATA_W  packed {R,G,B}, R in the MSBs.
REQ-010 in_user  input  USER_W  sideband, e.g. start-of-frame/end-of-line.
REQ-011 out_valid  output  1  output pixel present.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_hsv  output  3*DATA_W  packed {H,S,V}, H in the MSBs.
REQ-014 out_user  output  USER_W  in_user of the same pixel.

Function
REQ-015 Transfer occurs on a cycle with valid&ready&clk_en high; in_ready = clk_en & (!out_valid | out_ready | any pipeline bubble).
REQ-016 Three-stage pipeline; latency exactly 3 accepted-cycles in, 3 cycles to out_valid under continuous out_ready; throughput 1 pixel/cycle.
REQ-017 Stage 1: max, min, diff = max-min, sector select, signed numerator; max tie priority R over G over B.
REQ-018 Sectors: R max -> offset 0, num = G-B; G max -> offset 120, num = B-R; B max -> offset 240, num = R-G.
REQ-019 Stage 2: reciprocal lookups Rcp(x) = round(65536/x), Rcp(0) = 0, for x = max and x = diff.
REQ-020 Stage 3: hue_deg = offset + sign(num)*((60*|num|*Rcp(diff) + 32768) >> 16); if negative add 360; result 0..359.
REQ-021 HUE_MODE 0: H = hue_deg >> 1; HUE_MODE 1: H = (hue_deg*round(2^(16+DATA_W)/360) + 32768) >> 16, saturated to 2^DATA_W-1.
REQ-022 S = ((diff*(2^DATA_W-1)*Rcp(max) + 32768) >> 16), saturated to 2^DATA_W-1; V = max.
REQ-023 diff = 0 (grey, incl. black): H = 0, S = 0, V = max.
REQ-024 Stall: out_valid & !out_ready holds out_hsv/out_user stable, freezes full stages; bubbles collapse so no pixel is lost or duplicated.
REQ-025 Intermediate widths sized so no product overflows for DATA_W up to 12.

Reset
REQ-026 rst high at a clock edge clears all stage valid flags; out_valid = 0, out_hsv = 0, out_user = 0 next cycle.
REQ-027 rst overrides clk_en; pixels in flight are discarded, never emitted.
REQ-028 in_ready = 0 while rst high, 1 the first cycle after (given clk_en).

Structure
REQ-029 Shared package holds sector encoding enum, constants 60/120/240/360, RCP_FRAC = 16.
REQ-030 One sub-module rgb2hsv_recip: registered Rcp(x) lookup, parametrised on DATA_W, instantiated twice in stage 2.

Verification (DATA_W=8, HUE_MODE 0 unless stated)
REQ-031 in (255,0,0), (0,255,0), (0,0,255) back-to-back -> out {0,255,255}, {60,255,255}, {120,255,255} on cycles 3,4,5.
REQ-032 in (128,128,128) then (0,0,0) -> {0,0,128} then {0,0,0}.
REQ-033 in (255,0,128) -> hue_deg 330, out {165,255,255}; HUE_MODE 1 -> H = 235.
REQ-034 10 pixels streamed, out_ready toggled 1/0 randomly -> all 10 out in order, out_user matched, output stable while stalled.
REQ-035 rst asserted with 3 pixels in flight -> out_valid 0 next cycle, none of those pixels ever emitted; next input emerges after 3 cycles.
REQ-036 clk_en low 5 cycles mid-stream -> no handshake, outputs frozen, stream resumes with no loss.
